// File: rtl/serial_addsub_unit_pkg.sv
// Shared encodings and the carry helper for the bit-serial adder/subtractor.
package serial_addsub_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single 1-bit full adder; the only arithmetic cell in the serial datapath.
module full_adder_cell
  import serial_addsub_unit_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = majority(a, b, cin);

endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial two's-complement add/subtract, LSB first, one bit per clock.
// Result and flags live in shadow registers that only change on the last bit.
module serial_addsub_unit
  import serial_addsub_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_bout,
  output logic             overflow
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, b_sr_q;
  logic [WIDTH-2:0] res_sr_q;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, mode_q, cout_bout_q, overflow_q;
  logic             fa_s, fa_cout;
  logic             accept, last_bit;

  full_adder_cell u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .cout(fa_cout)
  );

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          last_bit = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments under an async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // The final sum bit is combined with the shifted bits and captured straight into result.
  assign res_next = {fa_s, res_sr_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      res_sr_q    <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      mode_q      <= MODE_ADD;
      cout_bout_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (accept) begin
      a_sr_q   <= a;
      b_sr_q   <= (mode == MODE_ADD) ? b : ~b;
      carry_q  <= mode;
      mode_q   <= mode;
      cnt_q    <= '0;
      res_sr_q <= '0;
    end else if (state_q == ST_RUN) begin
      a_sr_q   <= a_sr_q >> 1;
      b_sr_q   <= b_sr_q >> 1;
      carry_q  <= fa_cout;
      res_sr_q <= res_next[WIDTH-1:1];
      if (last_bit) begin
        // carry_q here is the carry into the MSB; fa_cout is the carry out of it.
        result_q    <= res_next;
        cout_bout_q <= (mode_q == MODE_SUB) ? ~fa_cout : fa_cout;
        overflow_q  <= carry_q ^ fa_cout;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign cout_bout = cout_bout_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Scoreboard bench for serial_addsub_unit (WIDTH=8): stimulus pushes expectations,
// a done-driven monitor pops and compares result, flags and start-to-done latency.
module tb_serial_addsub_unit;

  localparam int WIDTH   = 8;
  localparam int LATENCY = WIDTH + 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout_bout;
  logic             overflow;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             cb;
    logic             ov;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_cnt = 0;

  serial_addsub_unit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout_bout(cout_bout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        check("result",    {24'd0, result}, {24'd0, mon_e.res});
        check("cout_bout", {31'd0, cout_bout}, {31'd0, mon_e.cb});
        check("overflow",  {31'd0, overflow},  {31'd0, mon_e.ov});
        check("latency",   cyc_cnt - mon_e.cyc, LATENCY);
      end
    end
  end

  // Drive a request at the current negedge (does not push an expectation).
  task automatic drive(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic m);
    start = 1'b1;
    a     = av;
    b     = bv;
    mode  = m;
  endtask

  task automatic expect_op(input logic [WIDTH-1:0] res, input logic cb, input logic ov);
    exp_t e;
    e.res = res;
    e.cb  = cb;
    e.ov  = ov;
    e.cyc = cyc_cnt;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (done !== 1'b1 && i < 20);
    if (done !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done (t=%0t)", i, $time);
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic m,
                        input logic [WIDTH-1:0] res, input logic cb, input logic ov);
    drive(av, bv, m);
    expect_op(res, cb, ov);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
    check({tag, "_done"},      {31'd0, done},      32'd0);
    check({tag, "_result"},    {24'd0, result},    32'd0);
    check({tag, "_cout_bout"}, {31'd0, cout_bout}, 32'd0);
    check({tag, "_overflow"},  {31'd0, overflow},  32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic vectors.
    run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1);

    // A start pulse mid-RUN with different operands must be ignored.
    drive(8'h35, 8'h4A, 1'b0);
    expect_op(8'h7F, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    drive(8'hFF, 8'hFF, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("busy_ignored_start", {31'd0, busy}, 32'd1);
    wait_done();
    @(negedge clk);

    // Reset mid-RUN aborts: outputs clear at once and no done follows.
    drive(8'h55, 8'hAA, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("idle_after_abort_busy", {31'd0, busy}, 32'd0);

    // Normal operation after the abort.
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // Start held high: second op accepted in the DONE cycle.
    drive(8'hFF, 8'h01, 1'b0);
    expect_op(8'h00, 1'b1, 1'b0);
    wait_done();
    drive(8'h80, 8'h01, 1'b1);
    expect_op(8'h7F, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("busy_back_to_back", {31'd0, busy}, 32'd1);
    wait_done();
    @(negedge clk);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
